// File: rtl/icg_latch.sv
// Low-transparent enable latch with a synchronous clear.
// Kept as its own cell so synthesis can swap in the library clock-gate latch.
module icg_latch (
  input  logic ck,
  input  logic clr,
  input  logic d,
  output logic q
);

  // Starts closed so the gated clock comes up low instead of X.
  logic q_r = 1'b0;

  // Follow d while ck is low; clr forces the stored enable to 0.
  always_latch begin
    if (!ck) begin
      q_r <= clr ? 1'b0 : d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/icg.sv
// Integrated clock gate: CKG follows CK only for high phases whose enable
// was captured during the preceding low phase. SE forces the gate open for
// scan, RST closes it regardless of EN and SE.
module icg (
  input  logic CK,
  input  logic RST,
  input  logic EN,
  input  logic SE,
  output logic CKG
);

  logic en_q;

  icg_latch u_latch (
    .ck  (CK),
    .clr (RST),
    .d   (EN | SE),
    .q   (en_q)
  );

  // en_q is frozen while CK is high, so every pulse is a full CK high phase.
  assign CKG = CK & en_q;

  // Simulation checker: a gated pulse must open on a CK rise.
  always @(posedge CKG) begin
    assert (CK == 1'b1)
      else $error("icg: CKG rose while CK low");
  end

  // Simulation checker: a gated pulse must close on a CK fall, so CKG is never high in a low phase.
  always @(negedge CKG) begin
    assert (CK == 1'b0)
      else $error("icg: CKG fell while CK high (short pulse)");
  end

  // Simulation checker: the enable may only move while CK is low, otherwise pulse width would shrink.
  always @(en_q) begin
    assert (CK == 1'b0)
      else $error("icg: enable latch changed while CK high");
  end

endmodule

// File: tb/tb_icg.sv
// Self-checking bench for icg: one expected gate value per CK cycle is queued
// when the low-phase stimulus is driven and popped when the high phase arrives.
module tb_icg;

  localparam int unsigned HIGH_T = 50;
  localparam int unsigned LOW_T  = 51;

  logic CK  = 1'b0;
  logic RST = 1'b0;
  logic EN  = 1'b0;
  logic SE  = 1'b0;
  logic CKG;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned pulse_cnt = 0;
  int unsigned model_cnt = 0;
  logic        sb[$];
  time         t_rise = 0;

  icg dut (
    .CK  (CK),
    .RST (RST),
    .EN  (EN),
    .SE  (SE),
    .CKG (CKG)
  );

  // Period 101: low 51, high 50.
  initial begin
    forever begin
      #LOW_T  CK = 1'b1;
      #HIGH_T CK = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Pulse width of every gated pulse must equal the CK high time.
  always @(posedge CKG) begin
    t_rise = $time;
    pulse_cnt++;
  end

  always @(negedge CKG) begin
    check("pulse_width", 32'($time - t_rise), HIGH_T);
  end

  // Called in a low phase: drive inputs, queue the expected gate value,
  // then check the following high phase and the low phase after it.
  task automatic run_cycle(input logic en, input logic se, input logic rst, input logic flip_high);
    logic e;
    EN  = en;
    SE  = se;
    RST = rst;
    sb.push_back((en | se) & ~rst);
    model_cnt += 32'((en | se) & ~rst);
    @(posedge CK);
    #1;
    e = sb.pop_front();
    check("ckg_rise", 32'(CKG), 32'(e));
    #24;
    if (flip_high) EN = ~EN;
    #23;
    check("ckg_late", 32'(CKG), 32'(e));
    @(negedge CK);
    #1;
    check("ckg_low", 32'(CKG), 32'd0);
  endtask

  // Watchdog: the run must end on its own.
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "tb_icg timeout");
  end

  initial begin
    #1;
    check("init_ckg", 32'(CKG), 32'd0);

    // Reset held with enables active: gate stays closed.
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, 1'b1, 1'b0);

    // Idle: nothing enabled for 20 cycles.
    for (int i = 0; i < 20; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Burst of 32 enabled cycles, then off.
    pulse_cnt = 0;
    model_cnt = 0;
    for (int i = 0; i < 32; i++) run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)  run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("burst_count", pulse_cnt, 32'd32);

    // EN flipped in the middle of a high phase: current phase unaffected,
    // the new value only shows at the next rising edge.
    run_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Scan enable forces the gate open.
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    // Reset during scan closes the gate for as long as it is held.
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Random enables, scan and reset, changed only in low phases.
    pulse_cnt = 0;
    model_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      run_cycle(1'($urandom_range(0, 1)),
                1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 9) == 0),
                1'b0);
    end
    check("random_count", pulse_cnt, model_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
